// File: rtl/framebuffer_painter.sv
// framebuffer_painter: rectangle fill engine over an H_SIZE x V_SIZE, 3-bit/pixel
// frame store with an independent registered read port for the display path.
// Optional build macro CLEAR_ON_RESET_EN: after reset, sweep the whole frame
// to 3'b000 before accepting commands.
module framebuffer_painter #(
  parameter int H_SIZE     = 100,
  parameter int V_SIZE     = 100,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic [6:0]            iX0,
  input  logic [6:0]            iY0,
  input  logic [6:0]            iX1,
  input  logic [6:0]            iY1,
  input  logic [2:0]            iColor,
  output logic                  oBusy,
  output logic                  oDone,
  input  logic [ADDR_WIDTH-1:0] iReadAddress,
  output logic [2:0]            oReadColor
);

  localparam int                    DEPTH   = H_SIZE * V_SIZE;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
  localparam logic [6:0]            X_MAX   = 7'(H_SIZE - 1);
  localparam logic [6:0]            Y_MAX   = 7'(V_SIZE - 1);

`ifdef CLEAR_ON_RESET_EN
  typedef enum logic [1:0] {IDLE, CLEAR, FILL, DONE} state_t;
  localparam state_t                RST_STATE = CLEAR;
  localparam logic [ADDR_WIDTH-1:0] LAST_A    = ADDR_WIDTH'(DEPTH - 1);
  logic [ADDR_WIDTH-1:0] caddr;
`else
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  localparam state_t RST_STATE = IDLE;
`endif

  state_t state, nstate;

  // latched command and fill cursor
  logic [6:0] x, y, x0, x1, y1;
  logic [2:0] color;

  logic [2:0] mem [0:DEPTH-1];

  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [2:0]            wdata;
  logic [6:0]            x1c, y1c;
  logic                  empty;

  // corners are clamped to the frame before the empty-rectangle test
  assign x1c   = (iX1 > X_MAX) ? X_MAX : iX1;
  assign y1c   = (iY1 > Y_MAX) ? Y_MAX : iY1;
  assign empty = (iX0 > x1c) || (iY0 > y1c);

  // next-state, status outputs and write-port controls
  always_comb begin
    nstate = state;
    oBusy  = 1'b0;
    oDone  = 1'b0;
    we     = 1'b0;
    waddr  = ADDR_WIDTH'(y) * ADDR_WIDTH'(H_SIZE) + ADDR_WIDTH'(x);
    wdata  = color;
    case (state)
      IDLE: if (iStart) nstate = empty ? DONE : FILL;
`ifdef CLEAR_ON_RESET_EN
      CLEAR: begin
        oBusy = 1'b1;
        we    = 1'b1;
        waddr = caddr;
        wdata = 3'b000;
        if (caddr == LAST_A) nstate = IDLE;
      end
`endif
      FILL: begin
        oBusy = 1'b1;
        we    = 1'b1;
        if (x == x1 && y == y1) nstate = DONE;
      end
      DONE: begin
        oDone  = 1'b1;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // state register, command latch and row-major fill cursor
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= RST_STATE;
      x     <= '0;
      y     <= '0;
      x0    <= '0;
      x1    <= '0;
      y1    <= '0;
      color <= '0;
`ifdef CLEAR_ON_RESET_EN
      caddr <= '0;
`endif
    end else begin
      state <= nstate;
      case (state)
        IDLE: if (iStart) begin
          x0    <= iX0;
          x1    <= x1c;
          y1    <= y1c;
          x     <= iX0;
          y     <= iY0;
          color <= iColor;
        end
`ifdef CLEAR_ON_RESET_EN
        CLEAR: caddr <= caddr + 1'b1;
`endif
        FILL: begin
          if (x == x1) begin
            x <= x0;
            y <= y + 7'd1;
          end else begin
            x <= x + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // frame store write port; a reset edge never commits a pixel
  always_ff @(posedge Clock) begin
    if (we && !Reset) mem[waddr] <= wdata;
  end

  // registered display read; old data on a same-address write, zero off-frame
  always_ff @(posedge Clock) begin
    if (Reset)                    oReadColor <= 3'b000;
    else if (iReadAddress < DEPTH_A) oReadColor <= mem[iReadAddress];
    else                          oReadColor <= 3'b000;
  end

endmodule

// File: tb/tb_framebuffer_painter.sv
// Directed self-checking bench for framebuffer_painter (default 100x100 frame).
module tb_framebuffer_painter;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        iStart = 1'b0;
  logic [6:0]  iX0 = '0, iY0 = '0, iX1 = '0, iY1 = '0;
  logic [2:0]  iColor = '0;
  logic        oBusy, oDone;
  logic [13:0] iReadAddress = '0;
  logic [2:0]  oReadColor;

  int n_chk  = 0;
  int n_fail = 0;

  framebuffer_painter #(.H_SIZE(100), .V_SIZE(100), .ADDR_WIDTH(14)) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart),
    .iX0(iX0), .iY0(iY0), .iX1(iX1), .iY1(iY1), .iColor(iColor),
    .oBusy(oBusy), .oDone(oDone),
    .iReadAddress(iReadAddress), .oReadColor(oReadColor)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic rd(input int a, output logic [2:0] c);
    iReadAddress = a[13:0];
    tick();
    c = oReadColor;
  endtask

  // start a fill; cyc = edges after the start edge until oDone is seen.
  // glitch >= 0 pulses a second command at that cycle to prove it is ignored.
  task automatic run_fill(input int x0, input int y0, input int x1, input int y1,
                          input int c, input int glitch, output int cyc, output logic busy0);
    iX0 = x0[6:0]; iY0 = y0[6:0]; iX1 = x1[6:0]; iY1 = y1[6:0]; iColor = c[2:0];
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    busy0 = oBusy;
    cyc = 0;
    while (!oDone && cyc < 20000) begin
      if (cyc == glitch) begin
        iX0 = 7'd0; iY0 = 7'd3; iX1 = 7'd0; iY1 = 7'd3; iColor = 3'd2;
        iStart = 1'b1;
      end
      tick();
      iStart = 1'b0;
      cyc++;
    end
    if (!oDone) chk("done_timeout", 32'(oDone), 32'd1);
  endtask

  // single-pixel paint used to seed known background values
  task automatic paint(input int x, input int y, input int c);
    int cy;
    logic b;
    run_fill(x, y, x, y, c, -1, cy, b);
    tick();
  endtask

  initial begin
    int cyc;
    logic b0;
    logic [2:0] c;

    // reset wins over a simultaneous start
    iStart = 1'b1;
    tick();
    tick();
    iStart = 1'b0;
`ifdef CLEAR_ON_RESET_EN
    chk("rst_busy", 32'(oBusy), 32'd1);
`else
    chk("rst_busy", 32'(oBusy), 32'd0);
`endif
    chk("rst_done", 32'(oDone), 32'd0);
    chk("rst_rdata", 32'(oReadColor), 32'd0);
    Reset = 1'b0;
`ifdef CLEAR_ON_RESET_EN
    cyc = 0;
    while (oBusy && cyc < 20000) begin tick(); cyc++; end
    chk("clear_cycles", 32'(cyc), 32'd10000);
`else
    tick();
    chk("idle_after_rst", 32'(oBusy), 32'd0);
`endif

    // 2x2 fill at origin
    run_fill(0, 0, 1, 1, 5, -1, cyc, b0);
    chk("f1_busy_rise", 32'(b0), 32'd1);
    chk("f1_cycles", 32'(cyc), 32'd4);
    chk("f1_done_busy", 32'(oBusy), 32'd0);
    tick();
    chk("f1_done_pulse", 32'(oDone), 32'd0);
    rd(0, c);   chk("f1_rd0", 32'(c), 32'd5);
    rd(1, c);   chk("f1_rd1", 32'(c), 32'd5);
    rd(100, c); chk("f1_rd100", 32'(c), 32'd5);
    rd(101, c); chk("f1_rd101", 32'(c), 32'd5);

    // clamp at bottom-right corner; neighbour 9997 must survive
    paint(97, 99, 1);
    run_fill(98, 99, 120, 120, 3, -1, cyc, b0);
    chk("clamp_cycles", 32'(cyc), 32'd2);
    tick();
    rd(9998, c); chk("clamp_rd9998", 32'(c), 32'd3);
    rd(9999, c); chk("clamp_rd9999", 32'(c), 32'd3);
    rd(9997, c); chk("clamp_rd9997", 32'(c), 32'd1);

    // empty rectangle goes straight to DONE
    paint(3, 5, 4);
    run_fill(10, 5, 3, 5, 6, -1, cyc, b0);
    chk("empty_busy", 32'(b0), 32'd0);
    chk("empty_cycles", 32'(cyc), 32'd0);
    tick();
    chk("empty_pulse", 32'(oDone), 32'd0);
    rd(503, c); chk("empty_nowrite", 32'(c), 32'd4);

    // start pulsed mid-fill is ignored
    paint(0, 3, 4);
    run_fill(0, 2, 4, 2, 6, 2, cyc, b0);
    chk("glitch_cycles", 32'(cyc), 32'd5);
    tick();
    chk("glitch_idle", 32'(oBusy), 32'd0);
    rd(200, c); chk("glitch_rd200", 32'(c), 32'd6);
    rd(204, c); chk("glitch_rd204", 32'(c), 32'd6);
    rd(300, c); chk("glitch_rd300", 32'(c), 32'd4);

    // off-frame read address returns zero
    rd(0, c);     chk("oob_pre", 32'(c), 32'd5);
    rd(10000, c); chk("oob_rd", 32'(c), 32'd0);

    // read-during-write at address 42 returns the old value first
    paint(42, 0, 1);
    iReadAddress = 14'd42;
    iX0 = 7'd42; iY0 = 7'd0; iX1 = 7'd42; iY1 = 7'd0; iColor = 3'd7;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    tick();
    chk("rdw_old", 32'(oReadColor), 32'd1);
    chk("rdw_done", 32'(oDone), 32'd1);
    tick();
    chk("rdw_new", 32'(oReadColor), 32'd7);

    // reset aborts a full-frame fill after 50 writes
    paint(50, 0, 2);
    iX0 = 7'd0; iY0 = 7'd0; iX1 = 7'd99; iY1 = 7'd99; iColor = 3'd7;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("abort_done", 32'(oDone), 32'd0);
    chk("abort_rdata", 32'(oReadColor), 32'd0);
`ifdef CLEAR_ON_RESET_EN
    cyc = 0;
    while (oBusy && cyc < 20000) begin
      if (oDone) chk("abort_clear_done", 32'(oDone), 32'd0);
      tick();
      cyc++;
    end
    chk("abort_clear_cycles", 32'(cyc), 32'd10000);
    rd(0, c);  chk("abort_rd0", 32'(c), 32'd0);
    rd(49, c); chk("abort_rd49", 32'(c), 32'd0);
    rd(50, c); chk("abort_rd50", 32'(c), 32'd0);
`else
    chk("abort_busy", 32'(oBusy), 32'd0);
    cyc = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (oDone) cyc++;
    end
    chk("abort_no_done", 32'(cyc), 32'd0);
    rd(0, c);  chk("abort_rd0", 32'(c), 32'd7);
    rd(25, c); chk("abort_rd25", 32'(c), 32'd7);
    rd(49, c); chk("abort_rd49", 32'(c), 32'd7);
    rd(50, c); chk("abort_rd50", 32'(c), 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
